// File: rtl/ac_control_unit.sv
// Fetch/decode/execute sequencer for the accumulator machine.
// Drives PC step/load, memory handshake and ACC/ALU controls.
module ac_control_unit #(
  parameter int ADDR_W = 5,
  parameter int OP_W   = 3,
  parameter int CNT_W  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [OP_W+ADDR_W-1:0] instr_i,
  input  logic                   mem_ack_i,
  input  logic                   zero_i,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic                   addr_sel_o,
  output logic [ADDR_W-1:0]      operand_o,
  output logic [OP_W+ADDR_W-1:0] ir_o,
  output logic                   pc_inc_o,
  output logic                   jmp_en_o,
  output logic [ADDR_W-1:0]      jmp_addr_o,
  output logic                   acc_we_o,
  output logic [1:0]             alu_op_o,
  output logic                   halted_o,
  output logic [2:0]             state_o,
  output logic [CNT_W-1:0]       instr_cnt_o
);

  localparam int IW = OP_W + ADDR_W;

  localparam logic [OP_W-1:0] OP_NOP = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LDA = OP_W'(1);
  localparam logic [OP_W-1:0] OP_STA = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(4);
  localparam logic [OP_W-1:0] OP_JMP = OP_W'(5);
  localparam logic [OP_W-1:0] OP_JZ  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(7);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC_RD = 3'd2,
    S_EXEC_WR = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    ir;
  logic [CNT_W-1:0] cnt;
  logic [OP_W-1:0]  opc;
  logic             retire;
  logic             load_ir;

  logic       req, we, sel, inc, jmp, accwe, halted;
  logic [1:0] alu;

  assign opc = ir[IW-1 -: OP_W];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_FETCH;
      ir    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (load_ir) ir <= instr_i;
      if (retire) cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    we        = 1'b0;
    sel       = 1'b0;
    inc       = 1'b0;
    jmp       = 1'b0;
    accwe     = 1'b0;
    alu       = 2'b00;
    halted    = 1'b0;
    retire    = 1'b0;
    load_ir   = 1'b0;
    case (state)
      S_FETCH: begin
        req = 1'b1;
        if (mem_ack_i) begin
          load_ir   = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opc)
          OP_NOP, OP_LDA, OP_STA,
          OP_ADD, OP_SUB: inc = 1'b1;
          OP_JMP:         jmp = 1'b1;
          OP_JZ: begin
            jmp = zero_i;
            inc = !zero_i;
          end
          default: ;
        endcase
        case (opc)
          OP_LDA, OP_ADD,
          OP_SUB:  state_nxt = S_EXEC_RD;
          OP_STA:  state_nxt = S_EXEC_WR;
          OP_HLT: begin
            state_nxt = S_HALT;
            retire    = 1'b1;
          end
          default: begin
            state_nxt = S_FETCH;
            retire    = 1'b1;
          end
        endcase
      end
      S_EXEC_RD: begin
        req   = 1'b1;
        sel   = 1'b1;
        accwe = mem_ack_i;
        case (opc)
          OP_ADD:  alu = 2'b01;
          OP_SUB:  alu = 2'b10;
          default: alu = 2'b00;
        endcase
        if (mem_ack_i) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_EXEC_WR: begin
        req = 1'b1;
        we  = 1'b1;
        sel = 1'b1;
        if (mem_ack_i) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_HALT:  halted = 1'b1;
      default: state_nxt = S_FETCH;
    endcase
  end

  // Request and pulses drop as soon as reset asserts, not at the next edge.
  assign mem_req_o   = rst_ni & req;
  assign mem_we_o    = rst_ni & we;
  assign addr_sel_o  = rst_ni & sel;
  assign pc_inc_o    = rst_ni & inc;
  assign jmp_en_o    = rst_ni & jmp;
  assign acc_we_o    = rst_ni & accwe;
  assign alu_op_o    = rst_ni ? alu : 2'b00;
  assign halted_o    = rst_ni & halted;
  assign state_o     = state;
  assign ir_o        = ir;
  assign operand_o   = ir[ADDR_W-1:0];
  assign jmp_addr_o  = ir[ADDR_W-1:0];
  assign instr_cnt_o = cnt;

endmodule

// File: tb/tb_ac_control_unit.sv
// Self-checking bench for ac_control_unit: vector table of
// instructions expanded into per-cycle expectations via a queue.
module tb_ac_control_unit;

  localparam int ADDR_W = 5;
  localparam int OP_W   = 3;
  localparam int CNT_W  = 4;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [7:0] instr;
  logic       ack;
  logic       zero;
  logic       mem_req, mem_we, addr_sel;
  logic [4:0] operand, jmp_addr;
  logic [7:0] ir;
  logic       pc_inc, jmp_en, acc_we, halted;
  logic [1:0] alu_op;
  logic [2:0] state;
  logic [3:0] cnt;

  ac_control_unit #(
    .ADDR_W(ADDR_W), .OP_W(OP_W), .CNT_W(CNT_W)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .instr_i    (instr),
    .mem_ack_i  (ack),
    .zero_i     (zero),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .addr_sel_o (addr_sel),
    .operand_o  (operand),
    .ir_o       (ir),
    .pc_inc_o   (pc_inc),
    .jmp_en_o   (jmp_en),
    .jmp_addr_o (jmp_addr),
    .acc_we_o   (acc_we),
    .alu_op_o   (alu_op),
    .halted_o   (halted),
    .state_o    (state),
    .instr_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] instr;
    logic       zero;
    int         fw;
    int         ew;
    logic       inc;
    logic       jmp;
    logic [2:0] nxt;
    logic [1:0] alu;
  } vec_t;

  typedef struct {
    logic [2:0] st;
    logic       req, we, sel, inc, jmp, accwe, halted;
    logic [1:0] alu;
    logic [7:0] ir;
    logic [3:0] cnt;
  } exp_t;

  exp_t       sb[$];
  vec_t       tbl[8];
  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] ir_m  = '0;
  logic [3:0] cnt_m = '0;

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, want);
    end
  endtask

  function automatic exp_t base(logic [2:0] st);
    exp_t e;
    e = '{st: st, req: 0, we: 0, sel: 0, inc: 0, jmp: 0,
          accwe: 0, halted: 0, alu: 2'b00, ir: ir_m, cnt: cnt_m};
    return e;
  endfunction

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    cmp("state", state, e.st);
    cmp("mem_req", mem_req, e.req);
    cmp("mem_we", mem_we, e.we);
    cmp("addr_sel", addr_sel, e.sel);
    cmp("pc_inc", pc_inc, e.inc);
    cmp("jmp_en", jmp_en, e.jmp);
    cmp("acc_we", acc_we, e.accwe);
    cmp("alu_op", alu_op, e.alu);
    cmp("halted", halted, e.halted);
    cmp("ir", ir, e.ir);
    cmp("operand", operand, e.ir[4:0]);
    cmp("jmp_addr", jmp_addr, e.ir[4:0]);
    cmp("instr_cnt", cnt, e.cnt);
  endtask

  // Inputs already driven just after a rising edge; check mid-cycle.
  task automatic step(exp_t e);
    sb.push_back(e);
    @(negedge clk);
    pop_check();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    exp_t e;
    rst_ni = 1'b0;
    ack    = 1'b1;
    ir_m   = '0;
    cnt_m  = '0;
    #1;
    sb.push_back(base(3'd0));
    pop_check();
    @(posedge clk);
    #1;
    sb.push_back(base(3'd0));
    pop_check();
    rst_ni = 1'b1;
    ack    = 1'b0;
    e      = base(3'd0);
    e.req  = 1'b1;
    step(e);
  endtask

  task automatic run_vec(vec_t v, bit abort);
    exp_t e;
    zero = v.zero;
    for (int i = 0; i <= v.fw; i++) begin
      ack   = (i == v.fw);
      instr = (i == v.fw) ? v.instr : 8'($urandom);
      e     = base(3'd0);
      e.req = 1'b1;
      step(e);
    end
    ir_m  = v.instr;
    ack   = 1'b1;
    instr = 8'($urandom);
    e     = base(3'd1);
    e.inc = v.inc;
    e.jmp = v.jmp;
    step(e);
    if (v.nxt == 3'd0 || v.nxt == 3'd4) cnt_m++;
    if (v.nxt == 3'd2 || v.nxt == 3'd3) begin
      for (int i = 0; i <= v.ew; i++) begin
        ack     = (i == v.ew) && !abort;
        e       = base(v.nxt);
        e.req   = 1'b1;
        e.sel   = 1'b1;
        e.we    = (v.nxt == 3'd3);
        e.accwe = (v.nxt == 3'd2) && ack;
        e.alu   = (v.nxt == 3'd2) ? v.alu : 2'b00;
        step(e);
        if (abort) return;
      end
      cnt_m++;
    end
    ack = 1'b0;
  endtask

  initial begin
    vec_t lda, nop, sta, hlt;
    exp_t e;
    tbl = '{
      '{8'h2A, 1'b0, 0, 0, 1'b1, 1'b0, 3'd2, 2'b00},
      '{8'h63, 1'b0, 3, 2, 1'b1, 1'b0, 3'd2, 2'b01},
      '{8'h9F, 1'b0, 0, 1, 1'b1, 1'b0, 3'd2, 2'b10},
      '{8'hD9, 1'b1, 0, 0, 1'b0, 1'b1, 3'd0, 2'b00},
      '{8'hD9, 1'b0, 1, 0, 1'b1, 1'b0, 3'd0, 2'b00},
      '{8'h00, 1'b0, 2, 0, 1'b1, 1'b0, 3'd0, 2'b00},
      '{8'hA4, 1'b1, 0, 0, 1'b0, 1'b1, 3'd0, 2'b00},
      '{8'h47, 1'b0, 0, 2, 1'b1, 1'b0, 3'd3, 2'b00}
    };
    lda = '{8'h2A, 1'b0, 0, 1, 1'b1, 1'b0, 3'd2, 2'b00};
    nop = '{8'h00, 1'b0, 0, 0, 1'b1, 1'b0, 3'd0, 2'b00};
    sta = '{8'h47, 1'b0, 0, 0, 1'b1, 1'b0, 3'd3, 2'b00};
    hlt = '{8'hE0, 1'b1, 0, 0, 1'b0, 1'b0, 3'd4, 2'b00};

    rst_ni = 1'b1;
    instr  = '0;
    ack    = 1'b0;
    zero   = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    foreach (tbl[i]) run_vec(tbl[i], 1'b0);

    run_vec(lda, 1'b1);
    do_reset();

    for (int i = 0; i < 16; i++) run_vec(nop, 1'b0);
    cmp("cnt_wrap", cnt, 0);

    do_reset();
    run_vec(sta, 1'b0);
    run_vec(hlt, 1'b0);
    for (int i = 0; i < 20; i++) begin
      ack      = 1'($urandom);
      instr    = 8'($urandom);
      e        = base(3'd4);
      e.halted = 1'b1;
      step(e);
    end
    cmp("halt_cnt", cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
